// File: rtl/sort_pkg.sv
// Shared definitions for the parameterised bubble sorter: FSM state
// encoding and the out-of-order predicate used by the compare stage.
package sort_pkg;

  // Widest element the compare predicate handles; narrower elements are
  // sign- or zero-extended to this width before comparison.
  localparam int CMP_W = 64;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LD0      = 4'd1,
    ST_RD_WAIT0 = 4'd2,
    ST_CAP0     = 4'd3,
    ST_RDN      = 4'd4,
    ST_RD_WAIT  = 4'd5,
    ST_CMP      = 4'd6,
    ST_PEND     = 4'd7,
    ST_DONE     = 4'd8
  } sort_state_e;

  // True when x must move behind y. Equal values never report out of
  // order, which keeps the sort stable.
  function automatic logic ooo(input logic [CMP_W-1:0] x,
                               input logic [CMP_W-1:0] y,
                               input logic desc,
                               input logic sgn);
    logic lt_s;
    logic gt_s;
    if (sgn) begin
      lt_s = ($signed(x) < $signed(y));
      gt_s = ($signed(x) > $signed(y));
    end else begin
      lt_s = (x < y);
      gt_s = (x > y);
    end
    return desc ? lt_s : gt_s;
  endfunction

endpackage

// File: rtl/sort_cmp.sv
// Combinational compare for the sorter: extends both operands to the
// package compare width (sign- or zero-extension) and applies ooo().
module sort_cmp
  import sort_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              desc,
  input  logic              sgn,
  output logic              out_of_order
);

  logic [CMP_W-1:0] x_ext_s;
  logic [CMP_W-1:0] y_ext_s;

  // Extend operands so one fixed-width predicate serves every DATA_W.
  always_comb begin
    x_ext_s = '0;
    y_ext_s = '0;
    if (sgn) begin
      x_ext_s = CMP_W'($signed(x));
      y_ext_s = CMP_W'($signed(y));
    end else begin
      x_ext_s = CMP_W'(x);
      y_ext_s = CMP_W'(y);
    end
    out_of_order = ooo(x_ext_s, y_ext_s, desc, sgn);
  end

endmodule

// File: rtl/param_bubble_sort.sv
// In-place bubble sorter over an external SRAM with a registered read port.
// One read per compare: the larger (or smaller, when descending) element
// is carried in hold_r across the pass and only written back when it
// stops moving, so each compare costs RDN + RD_WAIT + CMP cycles.
module param_bubble_sort
  import sort_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int N_ELEM    = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Desc,
  input  logic              SignCmp,
  input  logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] RAddr,
  output logic [ADDR_W-1:0] WAddr,
  output logic [DATA_W-1:0] WData,
  output logic              Wen,
  output logic              Busy,
  output logic              Finish
);

  // Counters are one bit wider than the address so N_ELEM = 2**ADDR_W fits.
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  L_INIT    = CNT_W'(N_ELEM - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam bit                SHORT_RUN = (N_ELEM < 2);

  sort_state_e       state_r,   state_nxt_s;
  logic [CNT_W-1:0]  j_r,       j_nxt_s;
  logic [CNT_W-1:0]  l_r,       l_nxt_s;
  logic [DATA_W-1:0] hold_r,    hold_nxt_s;
  logic              swapped_r, swapped_nxt_s;
  logic              carry_r,   carry_nxt_s;
  logic              desc_r,    desc_nxt_s;
  logic              sgn_r,     sgn_nxt_s;
  logic [ADDR_W-1:0] raddr_r,   raddr_nxt_s;
  logic [ADDR_W-1:0] waddr_r,   waddr_nxt_s;
  logic [DATA_W-1:0] wdata_r,   wdata_nxt_s;
  logic              wen_r,     wen_nxt_s;
  logic              busy_r,    busy_nxt_s;
  logic              finish_r,  finish_nxt_s;

  logic [CNT_W-1:0]  j_plus1_s;
  logic [ADDR_W-1:0] addr_j_s;
  logic [ADDR_W-1:0] addr_j1_s;
  logic [ADDR_W-1:0] addr_l_s;
  logic              ooo_s;

  assign j_plus1_s = j_r + CNT_W'(1);
  assign addr_j_s  = BASE + j_r[ADDR_W-1:0];
  assign addr_j1_s = BASE + j_plus1_s[ADDR_W-1:0];
  assign addr_l_s  = BASE + l_r[ADDR_W-1:0];

  // hold_r is the carried element, RData the freshly read neighbour.
  sort_cmp #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .x           (hold_r),
    .y           (RData),
    .desc        (desc_r),
    .sgn         (sgn_r),
    .out_of_order(ooo_s)
  );

  // Next-state and next-register values; Wen defaults low so it pulses.
  always_comb begin
    state_nxt_s   = state_r;
    j_nxt_s       = j_r;
    l_nxt_s       = l_r;
    hold_nxt_s    = hold_r;
    swapped_nxt_s = swapped_r;
    carry_nxt_s   = carry_r;
    desc_nxt_s    = desc_r;
    sgn_nxt_s     = sgn_r;
    raddr_nxt_s   = raddr_r;
    waddr_nxt_s   = waddr_r;
    wdata_nxt_s   = wdata_r;
    wen_nxt_s     = 1'b0;
    busy_nxt_s    = busy_r;
    finish_nxt_s  = finish_r;

    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          desc_nxt_s = Desc;
          sgn_nxt_s  = SignCmp;
          if (SHORT_RUN) begin
            state_nxt_s  = ST_DONE;
            busy_nxt_s   = 1'b0;
            finish_nxt_s = 1'b1;
          end else begin
            state_nxt_s   = ST_LD0;
            busy_nxt_s    = 1'b1;
            l_nxt_s       = L_INIT;
            j_nxt_s       = '0;
            swapped_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_LD0: begin
        raddr_nxt_s = BASE;
        carry_nxt_s = 1'b0;
        state_nxt_s = ST_RD_WAIT0;
      end

      ST_RD_WAIT0: begin
        state_nxt_s = ST_CAP0;
      end

      ST_CAP0: begin
        hold_nxt_s  = RData;
        state_nxt_s = ST_RDN;
      end

      ST_RDN: begin
        raddr_nxt_s = addr_j1_s;
        state_nxt_s = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        state_nxt_s = ST_CMP;
      end

      ST_CMP: begin
        if (ooo_s) begin
          // Neighbour moves down; hold keeps travelling up the pass.
          wen_nxt_s     = 1'b1;
          waddr_nxt_s   = addr_j_s;
          wdata_nxt_s   = RData;
          swapped_nxt_s = 1'b1;
          carry_nxt_s   = 1'b1;
        end else begin
          // Hold stops here; its slot only needs writing if it travelled.
          if (carry_r) begin
            wen_nxt_s   = 1'b1;
            waddr_nxt_s = addr_j_s;
            wdata_nxt_s = hold_r;
          end else begin
            wen_nxt_s = 1'b0;
          end
          hold_nxt_s  = RData;
          carry_nxt_s = 1'b0;
        end
        if (j_plus1_s == l_r) begin
          state_nxt_s = ST_PEND;
        end else begin
          j_nxt_s     = j_plus1_s;
          state_nxt_s = ST_RDN;
        end
      end

      ST_PEND: begin
        if (carry_r) begin
          wen_nxt_s   = 1'b1;
          waddr_nxt_s = addr_l_s;
          wdata_nxt_s = hold_r;
        end else begin
          wen_nxt_s = 1'b0;
        end
        l_nxt_s = l_r - CNT_W'(1);
        // A swap-free pass, or the last single-compare pass, ends the sort.
        if (!swapped_r || (l_r == CNT_W'(1))) begin
          state_nxt_s  = ST_DONE;
          busy_nxt_s   = 1'b0;
          finish_nxt_s = 1'b1;
        end else begin
          j_nxt_s       = '0;
          swapped_nxt_s = 1'b0;
          state_nxt_s   = ST_LD0;
        end
      end

      ST_DONE: begin
        busy_nxt_s = 1'b0;
        if (Start) begin
          finish_nxt_s = 1'b1;
          state_nxt_s  = ST_DONE;
        end else begin
          finish_nxt_s = 1'b0;
          state_nxt_s  = ST_IDLE;
        end
      end

      default: begin
        state_nxt_s  = ST_IDLE;
        busy_nxt_s   = 1'b0;
        finish_nxt_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; rst aborts any sort in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      j_r       <= '0;
      l_r       <= '0;
      hold_r    <= '0;
      swapped_r <= 1'b0;
      carry_r   <= 1'b0;
      desc_r    <= 1'b0;
      sgn_r     <= 1'b0;
      raddr_r   <= '0;
      waddr_r   <= '0;
      wdata_r   <= '0;
      wen_r     <= 1'b0;
      busy_r    <= 1'b0;
      finish_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      j_r       <= j_nxt_s;
      l_r       <= l_nxt_s;
      hold_r    <= hold_nxt_s;
      swapped_r <= swapped_nxt_s;
      carry_r   <= carry_nxt_s;
      desc_r    <= desc_nxt_s;
      sgn_r     <= sgn_nxt_s;
      raddr_r   <= raddr_nxt_s;
      waddr_r   <= waddr_nxt_s;
      wdata_r   <= wdata_nxt_s;
      wen_r     <= wen_nxt_s;
      busy_r    <= busy_nxt_s;
      finish_r  <= finish_nxt_s;
    end
  end

  assign RAddr  = raddr_r;
  assign WAddr  = waddr_r;
  assign WData  = wdata_r;
  assign Wen    = wen_r;
  assign Busy   = busy_r;
  assign Finish = finish_r;

endmodule

// File: tb/tb_param_bubble_sort.sv
// Directed bench for param_bubble_sort. Four instances with different
// parameter sets share one clock; each has its own SRAM model
// (registered read, posedge write), write counter and Finish-rise counter.
module tb_param_bubble_sort;

  logic        clk;
  logic        rst    [4];
  logic        start  [4];
  logic        desc_v [4];
  logic        sgn_v  [4];
  logic [31:0] rdata  [4];

  logic [4:0]  raddr0, raddr1, raddr2, raddr3;
  logic [4:0]  waddr0, waddr1, waddr2, waddr3;
  logic [31:0] wdata0;
  logic [7:0]  wdata1, wdata2, wdata3;
  logic        wen0, wen1, wen2, wen3;
  logic        busy0, busy1, busy2, busy3;
  logic        fin0, fin1, fin2, fin3;

  logic [4:0]  raddr  [4];
  logic [4:0]  waddr  [4];
  logic [31:0] wdata  [4];
  logic        wen    [4];
  logic        busy   [4];
  logic        finish [4];

  logic [31:0] mem [4][32];
  logic        ld_en [4];
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        clr   [4];
  logic        fin_q [4];
  int          wcnt  [4];
  int          frise [4];

  logic [31:0] vec [16];
  logic [31:0] exp_v [16];
  int          n_checks;
  int          n_errors;
  int          cyc;

  // A: 32-bit, 8 elements
  param_bubble_sort #(.DATA_W(32), .ADDR_W(5), .N_ELEM(8), .BASE_ADDR(0)) u_a (
    .clk(clk), .rst(rst[0]), .Start(start[0]), .Desc(desc_v[0]), .SignCmp(sgn_v[0]),
    .RData(rdata[0]), .RAddr(raddr0), .WAddr(waddr0), .WData(wdata0),
    .Wen(wen0), .Busy(busy0), .Finish(fin0));

  // B: 8-bit, 4 elements
  param_bubble_sort #(.DATA_W(8), .ADDR_W(5), .N_ELEM(4), .BASE_ADDR(0)) u_b (
    .clk(clk), .rst(rst[1]), .Start(start[1]), .Desc(desc_v[1]), .SignCmp(sgn_v[1]),
    .RData(rdata[1][7:0]), .RAddr(raddr1), .WAddr(waddr1), .WData(wdata1),
    .Wen(wen1), .Busy(busy1), .Finish(fin1));

  // C: 8-bit, 16 elements
  param_bubble_sort #(.DATA_W(8), .ADDR_W(5), .N_ELEM(16), .BASE_ADDR(0)) u_c (
    .clk(clk), .rst(rst[2]), .Start(start[2]), .Desc(desc_v[2]), .SignCmp(sgn_v[2]),
    .RData(rdata[2][7:0]), .RAddr(raddr2), .WAddr(waddr2), .WData(wdata2),
    .Wen(wen2), .Busy(busy2), .Finish(fin2));

  // D: single element at base 5
  param_bubble_sort #(.DATA_W(8), .ADDR_W(5), .N_ELEM(1), .BASE_ADDR(5)) u_d (
    .clk(clk), .rst(rst[3]), .Start(start[3]), .Desc(desc_v[3]), .SignCmp(sgn_v[3]),
    .RData(rdata[3][7:0]), .RAddr(raddr3), .WAddr(waddr3), .WData(wdata3),
    .Wen(wen3), .Busy(busy3), .Finish(fin3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gather per-instance outputs into indexable arrays.
  always_comb begin
    raddr[0] = raddr0; raddr[1] = raddr1; raddr[2] = raddr2; raddr[3] = raddr3;
    waddr[0] = waddr0; waddr[1] = waddr1; waddr[2] = waddr2; waddr[3] = waddr3;
    wdata[0] = wdata0;
    wdata[1] = {24'h0, wdata1};
    wdata[2] = {24'h0, wdata2};
    wdata[3] = {24'h0, wdata3};
    wen[0]  = wen0;  wen[1]  = wen1;  wen[2]  = wen2;  wen[3]  = wen3;
    busy[0] = busy0; busy[1] = busy1; busy[2] = busy2; busy[3] = busy3;
    finish[0] = fin0; finish[1] = fin1; finish[2] = fin2; finish[3] = fin3;
  end

  // SRAM models plus write and Finish-rise counters.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      rdata[k] <= mem[k][raddr[k]];
      if (ld_en[k]) mem[k][ld_addr] <= ld_data;
      else if (wen[k]) mem[k][waddr[k]] <= wdata[k];
      fin_q[k] <= finish[k];
      if (clr[k]) begin
        wcnt[k]  <= 0;
        frise[k] <= 0;
      end else begin
        if (wen[k]) wcnt[k] <= wcnt[k] + 1;
        if (finish[k] && !fin_q[k]) frise[k] <= frise[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      ld_en[k] = 1'b1;
      ld_addr  = 5'(base + i);
      ld_data  = vec[i];
      tick();
    end
    ld_en[k] = 1'b0;
  endtask

  task automatic clear_cnt(input int k);
    clr[k] = 1'b1;
    tick();
    clr[k] = 1'b0;
  endtask

  task automatic check_mem(input string tag, input int k, input int base, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), mem[k][base + i], exp_v[i]);
  endtask

  // Start a sort, wait for Finish within budget, then release Start.
  task automatic run(input string tag, input int k, input logic d, input logic s,
                     input int budget, output int cycles);
    start[k]  = 1'b1;
    desc_v[k] = d;
    sgn_v[k]  = s;
    tick();
    cycles = 1;
    check({tag, "_busy"}, {31'd0, busy[k]}, 32'd1);
    while (finish[k] !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    check({tag, "_finish"}, {31'd0, finish[k]}, 32'd1);
    start[k] = 1'b0;
    tick();
    check({tag, "_finish_clr"}, {31'd0, finish[k]}, 32'd0);
    tick();
  endtask

  // Unsigned ascending insertion sort of exp_v[0..n-1].
  function automatic void sort_exp(input int n);
    logic [31:0] t;
    int          j;
    for (int i = 1; i < n; i++) begin
      t = exp_v[i];
      j = i - 1;
      while (j >= 0 && exp_v[j] > t) begin
        exp_v[j + 1] = exp_v[j];
        j--;
      end
      exp_v[j + 1] = t;
    end
  endfunction

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    ld_addr  = 5'd0;
    ld_data  = 32'd0;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; desc_v[k] = 1'b0; sgn_v[k] = 1'b0;
      ld_en[k] = 1'b0; clr[k] = 1'b1;
    end
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b0; clr[k] = 1'b0;
    end

    // Reset state
    check("rst_busy",   {31'd0, busy0}, 32'd0);
    check("rst_finish", {31'd0, fin0},  32'd0);
    check("rst_wen",    {31'd0, wen0},  32'd0);
    check("rst_raddr",  {27'd0, raddr0}, 32'd0);
    check("rst_waddr",  {27'd0, waddr0}, 32'd0);
    check("rst_wdata",  wdata0, 32'd0);

    // 1: unsigned ascending, 8 elements
    vec = '{0:32'd5, 1:32'd3, 2:32'd7, 3:32'd1, 4:32'd0, 5:32'd6, 6:32'd2, 7:32'd4, default:32'd0};
    load(0, 0, 8);
    clear_cnt(0);
    run("t1", 0, 1'b0, 1'b0, 1000, cyc);
    exp_v = '{0:32'd0, 1:32'd1, 2:32'd2, 3:32'd3, 4:32'd4, 5:32'd5, 6:32'd6, 7:32'd7, default:32'd0};
    check_mem("t1_mem", 0, 0, 8);
    check("t1_finish_rises", 32'(frise[0]), 32'd1);

    // 2: 8-bit signed vs unsigned ascending
    vec = '{0:32'hFF, 1:32'h01, 2:32'h80, 3:32'h7F, default:32'd0};
    load(1, 0, 4);
    run("t2s", 1, 1'b0, 1'b1, 200, cyc);
    exp_v = '{0:32'h80, 1:32'hFF, 2:32'h01, 3:32'h7F, default:32'd0};
    check_mem("t2s_mem", 1, 0, 4);
    load(1, 0, 4);
    run("t2u", 1, 1'b0, 1'b0, 200, cyc);
    exp_v = '{0:32'h01, 1:32'h7F, 2:32'h80, 3:32'hFF, default:32'd0};
    check_mem("t2u_mem", 1, 0, 4);

    // 3: already sorted, one pass, no writes
    for (int i = 0; i < 16; i++) vec[i] = 32'(i * 3);
    load(2, 0, 16);
    clear_cnt(2);
    run("t3", 2, 1'b0, 1'b0, 55, cyc);
    check("t3_cycles_le_55", {31'd0, (cyc <= 55)}, 32'd1);
    check("t3_wen_count", 32'(wcnt[2]), 32'd0);
    for (int i = 0; i < 16; i++) exp_v[i] = 32'(i * 3);
    check_mem("t3_mem", 2, 0, 16);

    // 4: descending with equal keys; a swapped equal pair would add writes
    vec = '{0:32'd2, 1:32'd2, 2:32'd9, 3:32'd1, default:32'd0};
    load(1, 0, 4);
    clear_cnt(1);
    run("t4", 1, 1'b1, 1'b0, 200, cyc);
    exp_v = '{0:32'd9, 1:32'd2, 2:32'd2, 3:32'd1, default:32'd0};
    check_mem("t4_mem", 1, 0, 4);
    check("t4_wen_count", 32'(wcnt[1]), 32'd4);

    // 5: reset mid-sort, then re-sort current contents
    vec = '{0:32'd5, 1:32'd3, 2:32'd7, 3:32'd1, 4:32'd0, 5:32'd6, 6:32'd2, 7:32'd4, default:32'd0};
    load(0, 0, 8);
    start[0] = 1'b1;
    desc_v[0] = 1'b0;
    sgn_v[0] = 1'b0;
    repeat (20) tick();
    check("t5_busy_mid", {31'd0, busy0}, 32'd1);
    rst[0] = 1'b1;
    start[0] = 1'b0;
    tick();
    check("t5_rst_busy",   {31'd0, busy0}, 32'd0);
    check("t5_rst_finish", {31'd0, fin0},  32'd0);
    check("t5_rst_wen",    {31'd0, wen0},  32'd0);
    rst[0] = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) exp_v[i] = mem[0][i];
    sort_exp(8);
    run("t5", 0, 1'b0, 1'b0, 1000, cyc);
    check_mem("t5_mem", 0, 0, 8);

    // 6: single element; Start held high after DONE
    vec = '{0:32'd42, default:32'd0};
    load(3, 5, 1);
    clear_cnt(3);
    start[3] = 1'b1;
    cyc = 0;
    while (fin3 !== 1'b1 && cyc < 2) begin
      tick();
      cyc++;
    end
    check("t6_finish_fast", {31'd0, fin3}, 32'd1);
    repeat (10) tick();
    check("t6_finish_held", {31'd0, fin3},  32'd1);
    check("t6_busy_held",   {31'd0, busy3}, 32'd0);
    check("t6_wen_count",   32'(wcnt[3]),  32'd0);
    check("t6_finish_rises", 32'(frise[3]), 32'd1);
    start[3] = 1'b0;
    tick();
    check("t6_finish_clr", {31'd0, fin3}, 32'd0);
    check("t6_mem", mem[3][5], 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
